// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard / halt controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [4:0] REG_A7    = 5'd17;
  localparam int unsigned HALT_CODE = 10;

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of hazards that forwarding cannot cover:
// load-use on rs1/rs2 and an ecall whose a7 operand is not yet available.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       IF_ID_use_rs1,
  input  logic       IF_ID_use_rs2,
  input  logic       IF_ID_is_ecall,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_MemRead,
  output logic       load_use,
  output logic       ecall_dep
);

  always_comb begin
    load_use  = ID_EX_MemRead && (ID_EX_rd != '0) &&
                ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                 (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));
    // a7 still in flight: produced in EX, or a load result not back until after MEM
    ecall_dep = IF_ID_is_ecall &&
                ((ID_EX_RegWrite && (ID_EX_rd == REG_A7)) ||
                 (EX_MEM_MemRead && (EX_MEM_rd == REG_A7)));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/bubble control, halt sequencing (RUN -> DRAIN -> HALTED) and a
// saturating counter of hazard-stall cycles.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic             IF_ID_is_ecall,
  input  logic             ecall_is_halt,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_MemRead,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_bubble,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic            load_use, ecall_dep, hazard, halt_req;
  logic            freeze, count_stall;

  hazard_detect u_detect (
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .IF_ID_use_rs1  (IF_ID_use_rs1),
    .IF_ID_use_rs2  (IF_ID_use_rs2),
    .IF_ID_is_ecall (IF_ID_is_ecall),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_RegWrite (ID_EX_RegWrite),
    .EX_MEM_rd      (EX_MEM_rd),
    .EX_MEM_MemRead (EX_MEM_MemRead),
    .load_use       (load_use),
    .ecall_dep      (ecall_dep)
  );

  assign hazard   = load_use || ecall_dep;
  // ecall_is_halt depends on a forwarded a7, so it is only trusted without ecall_dep
  assign halt_req = (state == RUN) && IF_ID_is_ecall && ecall_is_halt && !hazard;

  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    freeze      = 1'b1;
    count_stall = 1'b0;
    case (state)
      RUN: begin
        freeze      = hazard || halt_req;
        count_stall = hazard;
        if (halt_req) begin
          state_nxt = DRAIN;
          drain_nxt = DW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = HALTED;
        else                 drain_nxt = drain_cnt - 1'b1;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      drain_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (count_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign is_halted    = (state == HALTED);
  assign PCWrite      = reset_n && !freeze;
  assign IF_ID_Write  = reset_n && !freeze;
  assign ID_EX_bubble = !reset_n || freeze;

endmodule
